// File: rtl/led_pattern_gen_pkg.sv
// Shared definitions for the LED pattern engine: mode encoding and bounce
// direction values used by the top level and by the bench.
package led_pattern_gen_pkg;

  typedef enum logic [1:0] {
    MODE_ROTL   = 2'd0,
    MODE_ROTR   = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_e;

  // Bounce direction: UP walks toward the MSB, DN walks toward the LSB.
  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

endpackage

// File: rtl/led_pattern_gen_tick_gen.sv
// Prescaler: counts enabled clocks and raises a combinational step on the
// terminal count, so one step occurs every CNT_MAX+1 enabled clocks.
// en=0 freezes the count; clr restarts it from zero.
module tick_gen #(
  parameter int CNT_MAX = 25000000 - 1,
  parameter int CNT_W   = 25
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic step
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(CNT_MAX);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  // Step fires in the enabled cycle that sits on the terminal count.
  assign step = en && (cnt == TERM);

  // Next count: clear wins, then wrap at the terminal count, else increment.
  always_comb begin
    cnt_nxt = cnt;
    if (clr) begin
      cnt_nxt = '0;
    end else if (en) begin
      if (cnt == TERM) cnt_nxt = '0;
      else             cnt_nxt = cnt + CNT_W'(1);
    end
  end

  // Count register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= cnt_nxt;
  end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern engine. A prescaler step advances an N_LED-wide pattern in one
// of four run-time modes (rotate-left, rotate-right, bounce, blink-all).
// The mode input is only looked at on a step; a change of mode costs one step
// for the entry action before the new mode starts moving the pattern.
module led_pattern_gen
  import led_pattern_gen_pkg::*;
#(
  parameter int N_LED   = 4,
  parameter int CNT_MAX = 25000000 - 1,
  parameter int CNT_W   = 25
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [1:0]       mode,
  output logic [N_LED-1:0] led,
  output logic             tick,
  output logic             dir
);

  localparam logic [N_LED-1:0] LED_INIT = {{(N_LED-1){1'b0}}, 1'b1};
  localparam logic [N_LED-1:0] LED_ALL  = {N_LED{1'b1}};

  logic             step;
  mode_e            mode_in;
  mode_e            mode_q;
  mode_e            mode_nxt;
  logic [N_LED-1:0] led_nxt;
  logic             dir_nxt;
  logic             tick_nxt;

  assign mode_in = mode_e'(mode);

  tick_gen #(
    .CNT_MAX (CNT_MAX),
    .CNT_W   (CNT_W)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .clr   (clr),
    .step  (step)
  );

  // Next pattern/direction/mode: clear first, then mode entry or mode step.
  always_comb begin
    led_nxt  = led;
    dir_nxt  = dir;
    mode_nxt = mode_q;
    tick_nxt = 1'b0;
    if (clr) begin
      led_nxt  = LED_INIT;
      dir_nxt  = DIR_UP;
      mode_nxt = MODE_ROTL;
    end else if (step) begin
      tick_nxt = 1'b1;
      if (mode_in != mode_q) begin
        // Entry step: only the entry action happens, no movement.
        mode_nxt = mode_in;
        if (mode_in == MODE_BLINK) begin
          led_nxt = LED_ALL;
        end else if (mode_q == MODE_BLINK) begin
          led_nxt = LED_INIT;
          dir_nxt = DIR_UP;
        end
      end else begin
        case (mode_q)
          MODE_ROTL: led_nxt = {led[N_LED-2:0], led[N_LED-1]};
          MODE_ROTR: led_nxt = {led[0], led[N_LED-1:1]};
          MODE_BOUNCE: begin
            // Reverse on the end LED itself, so the ends are not repeated.
            if (dir == DIR_UP && led[N_LED-1]) begin
              dir_nxt = DIR_DN;
              led_nxt = led >> 1;
            end else if (dir == DIR_DN && led[0]) begin
              dir_nxt = DIR_UP;
              led_nxt = led << 1;
            end else if (dir == DIR_UP) begin
              led_nxt = led << 1;
            end else begin
              led_nxt = led >> 1;
            end
          end
          MODE_BLINK: led_nxt = (led == LED_ALL) ? '0 : LED_ALL;
          default:    led_nxt = led;
        endcase
      end
    end
  end

  // Output and mode registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led    <= LED_INIT;
      dir    <= DIR_UP;
      tick   <= 1'b0;
      mode_q <= MODE_ROTL;
    end else begin
      led    <= led_nxt;
      dir    <= dir_nxt;
      tick   <= tick_nxt;
      mode_q <= mode_nxt;
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: directed scenarios followed by random traffic,
// every cycle compared against a position-based reference model.
module tb_led_pattern_gen;

  localparam int N = 4;
  localparam int CM = 3;

  // Clock and reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // DUT with CNT_MAX=3
  logic         en, clr;
  logic [1:0]   mode;
  logic [N-1:0] led;
  logic         tick, dir;

  // DUT with CNT_MAX=0
  logic         en2;
  logic         clr2 = 1'b0;
  logic [1:0]   mode2 = 2'd0;
  logic [N-1:0] led2;
  logic         tick2, dir2;

  led_pattern_gen #(.N_LED(N), .CNT_MAX(CM), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .mode(mode),
    .led(led), .tick(tick), .dir(dir)
  );

  led_pattern_gen #(.N_LED(N), .CNT_MAX(0), .CNT_W(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en2), .clr(clr2), .mode(mode2),
    .led(led2), .tick(tick2), .dir(dir2)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: the lit LED is held as a position, blink as a flag.
  int   m_ph, m_pos, m_pos2;
  bit   m_dir, m_blink_on, m_tick, m_tick2;
  logic [1:0] m_mode_q;

  logic [N+1:0] exp_q[$];

  function automatic logic [N-1:0] m_led();
    if (m_mode_q == 2'd3) return m_blink_on ? {N{1'b1}} : '0;
    return N'(1 << m_pos);
  endfunction

  task automatic model_reset();
    m_ph = 0; m_pos = 0; m_dir = 0; m_blink_on = 0; m_tick = 0;
    m_mode_q = 2'd0; m_pos2 = 0; m_tick2 = 0;
  endtask

  task automatic model_step();
    if (mode != m_mode_q) begin
      if (mode == 2'd3) m_blink_on = 1;
      else if (m_mode_q == 2'd3) begin m_pos = 0; m_dir = 0; end
      m_mode_q = mode;
    end else begin
      case (m_mode_q)
        2'd0: m_pos = (m_pos + 1) % N;
        2'd1: m_pos = (m_pos + N - 1) % N;
        2'd2: begin
          if (!m_dir) begin
            if (m_pos == N - 1) begin m_dir = 1; m_pos--; end
            else m_pos++;
          end else begin
            if (m_pos == 0) begin m_dir = 0; m_pos++; end
            else m_pos--;
          end
        end
        default: m_blink_on = !m_blink_on;
      endcase
    end
  endtask

  // Advance the model by one clock edge using the inputs seen at that edge.
  task automatic model_edge();
    bit stp;
    if (!rst_n) begin
      model_reset();
    end else begin
      if (clr) begin
        m_ph = 0; m_pos = 0; m_dir = 0; m_blink_on = 0; m_mode_q = 2'd0; m_tick = 0;
      end else begin
        stp = en && (m_ph == CM);
        if (en) m_ph = stp ? 0 : m_ph + 1;
        m_tick = stp;
        if (stp) model_step();
      end
      m_tick2 = en2;
      if (en2) m_pos2 = (m_pos2 + 1) % N;
    end
    exp_q.push_back({m_tick, m_dir, m_led()});
  endtask

  // Scoreboard: pop the expected outputs and compare both DUTs.
  task automatic compare();
    logic [N+1:0] e;
    e = exp_q.pop_front();
    checks++;
    assert (led === e[N-1:0]) else begin
      errors++; $error("FAIL led: got %b expected %b", led, e[N-1:0]);
    end
    checks++;
    assert (dir === e[N]) else begin
      errors++; $error("FAIL dir: got %b expected %b", dir, e[N]);
    end
    checks++;
    assert (tick === e[N+1]) else begin
      errors++; $error("FAIL tick: got %b expected %b", tick, e[N+1]);
    end
    checks++;
    assert (led2 === N'(1 << m_pos2) && dir2 === 1'b0) else begin
      errors++; $error("FAIL led2: got %b/%b expected %b/0", led2, dir2, N'(1 << m_pos2));
    end
    checks++;
    assert (tick2 === m_tick2) else begin
      errors++; $error("FAIL tick2: got %b expected %b", tick2, m_tick2);
    end
  endtask

  // Driver: one clock, model update, sample 1 ns after the edge.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Run until the next tick (bounded) and check the new LED value and latency.
  task automatic step_expect(input logic [N-1:0] want, input int want_cyc, input string tag);
    int n;
    bit seen;
    n = 0; seen = 0;
    while (!seen && n < 16) begin
      cycle();
      n++;
      if (tick === 1'b1) seen = 1;
    end
    checks++;
    assert (seen && led === want) else begin
      errors++; $error("FAIL %s: led=%b seen=%0d expected led=%b", tag, led, seen, want);
    end
    checks++;
    assert (n == want_cyc) else begin
      errors++; $error("FAIL %s_lat: cycles=%0d expected %0d", tag, n, want_cyc);
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; mode = 2'd0; en2 = 1'b0;
    model_reset();
    #12;
    checks++;
    assert (led === 4'b0001 && tick === 1'b0 && dir === 1'b0) else begin
      errors++; $error("FAIL reset: led=%b tick=%b dir=%b expected 0001/0/0", led, tick, dir);
    end
    #2 rst_n = 1'b1;
    @(negedge clk);

    // 1: rotate-left, tick every 4 clocks
    en = 1'b1;
    step_expect(4'b0010, 4, "rotl1");
    step_expect(4'b0100, 4, "rotl2");
    step_expect(4'b1000, 4, "rotl3");
    step_expect(4'b0001, 4, "rotl4");

    // 2: bounce, entry step keeps the LED
    mode = 2'd2;
    step_expect(4'b0001, 4, "bnc_entry");
    step_expect(4'b0010, 4, "bnc1");
    step_expect(4'b0100, 4, "bnc2");
    step_expect(4'b1000, 4, "bnc3");
    step_expect(4'b0100, 4, "bnc4");
    checks++;
    assert (dir === 1'b1) else begin
      errors++; $error("FAIL bnc_dir: got %b expected 1", dir);
    end
    step_expect(4'b0010, 4, "bnc5");
    step_expect(4'b0001, 4, "bnc6");
    step_expect(4'b0010, 4, "bnc7");
    step_expect(4'b0100, 4, "bnc8");

    // 3: blink then rotate-right
    mode = 2'd3;
    step_expect(4'b1111, 4, "blk1");
    step_expect(4'b0000, 4, "blk2");
    step_expect(4'b1111, 4, "blk3");
    mode = 2'd1;
    step_expect(4'b0001, 4, "rotr_entry");
    step_expect(4'b1000, 4, "rotr1");
    step_expect(4'b0100, 4, "rotr2");

    // 4: freeze mid-count for 10 clocks, phase is kept
    run(2);
    en = 1'b0;
    run(10);
    en = 1'b1;
    step_expect(4'b0010, 2, "freeze");

    // 5: clear in the step cycle
    mode = 2'd0;
    step_expect(4'b0010, 4, "rotl_entry");
    run(3);
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    checks++;
    assert (led === 4'b0001 && tick === 1'b0) else begin
      errors++; $error("FAIL clr: led=%b tick=%b expected 0001/0", led, tick);
    end
    step_expect(4'b0010, 4, "after_clr");

    // 6: asynchronous reset mid-period
    run(2);
    @(posedge clk);
    model_edge();
    #1 compare();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    assert (led === 4'b0001 && tick === 1'b0 && dir === 1'b0) else begin
      errors++; $error("FAIL async_rst: led=%b tick=%b dir=%b expected 0001/0/0", led, tick, dir);
    end
    run(2);
    #3 rst_n = 1'b1;
    step_expect(4'b0010, 4, "after_rst");

    // 7: CNT_MAX=0 instance steps on every enabled clock
    en2 = 1'b1;
    run(7);
    checks++;
    assert (led2 === 4'b1000 && tick2 === 1'b1) else begin
      errors++; $error("FAIL cm0: led2=%b tick2=%b expected 1000/1", led2, tick2);
    end
    en2 = 1'b0;
    run(1);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      en  = ($urandom_range(0, 9) < 8);
      clr = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
      en2 = ($urandom_range(0, 1) == 1);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
